led_rate_generator: RTL and testbench
=====================================

Name: led_rate_generator

Overview:
- Upstream stage of led_controller. Divides the 50 MHz board clock into the slow step clock that led_controller consumes on its clk input.
- Also emits a one-cycle tick strobe for synchronous consumers.
- Pushbuttons select the step rate (speed up / slow down) and pause/resume the sweep.
- Raw active-low keys are synchronised and debounced inside the block.

Parameters:
- BASE_DIV, 25_000_000, tick divisor at level 0 (2 Hz ticks at 50 MHz); divisor at level L = BASE_DIV >> L
- LEVELS, 8, number of rate levels; BASE_DIV >> (LEVELS-1) must be >= 2
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a key change is accepted (20 ms)

Ports:
- clk  input  1  system clock, 50 MHz
- reset_n  input  1  synchronous active-low reset
- key_faster_n  input  1  raw pushbutton, active-low, asynchronous
- key_slower_n  input  1  raw pushbutton, active-low, asynchronous
- key_pause_n  input  1  raw pushbutton, active-low, asynchronous
- tick  output  1  one-cycle pulse per divisor period
- slow_clk  output  1  square wave toggling on every tick; drives led_controller clk
- rate_level  output  $clog2(LEVELS)  current level, 0 = slowest
- paused  output  1  high while in PAUSED

Behaviour:
- Reset:
  - reset_n sampled low at a clk edge forces tick=0, slow_clk=0, rate_level=0, paused=0.
  - Clears divide counter, synchroniser flops (to 1), debounced key states (to 1) and debounce counters.
  - Reset mid-operation aborts any in-progress debounce and count.
- Key path, per key:
  - 2-flop synchroniser.
  - Debounce counter increments each cycle the synchronised value differs from the debounced value, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the synchronised value and the counter clears.
  - A press event is a registered one-cycle pulse on a debounced 1->0 transition. Releases generate nothing.
  - Total latency: the action takes effect on edge 2+DEBOUNCE_CYCLES+1 after the raw key falls.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Level:
  - Faster event: rate_level+1, saturating at LEVELS-1.
  - Slower event: rate_level-1, saturating at 0.
  - Faster and slower events in the same cycle: no change.
  - Any cycle in which rate_level actually changes clears the divide counter; no tick that cycle.
  - A saturated press (no change) does not clear the counter.
- Divider:
  - divisor = BASE_DIV >> rate_level.
  - Counter runs 0..divisor-1 in RUN.
  - On the cycle count == divisor-1: tick=1, count returns to 0, slow_clk toggles.
  - slow_clk period = 2*divisor cycles, 50% duty.
- State machine (RUN, PAUSED):
  - Reset state is RUN.
  - A pause event toggles the state; paused=1 exactly in PAUSED.
  - In PAUSED: counter holds, tick=0, slow_clk holds its level. Level keys still update rate_level and clear the counter.
  - On return to RUN, counting resumes from the held count.
  - A pause event coinciding with terminal count: the tick for that cycle is still issued, then PAUSED.

Optional Feature:
- Macro: LED_RATE_WRAP_EN.
- Defined: level arithmetic wraps instead of saturating. Faster at LEVELS-1 goes to 0; slower at 0 goes to LEVELS-1. These wraps count as a change and clear the counter.
- Undefined: saturating behaviour as specified above.

Test Plan:
Bench parameters: BASE_DIV=64, LEVELS=4, DEBOUNCE_CYCLES=4.
- Release reset, keys high -> first tick on the 64th edge after release, then every 64 cycles; slow_clk toggles at each tick (period 128); rate_level=0, paused=0.
- key_faster_n low for 20 cycles -> rate_level=1 on edge 7 after the fall; counter cleared; ticks every 32 cycles. Releasing the key causes no change.
- key_faster_n pulses low 3 cycles / high 1 cycle, repeated 10 times -> rate_level stays 0. Then 5 clean presses -> rate_level saturates at 3; ticks every 8 cycles.
- Pause press at count 20 -> paused=1, no tick for 300 cycles, slow_clk constant. Second press -> paused=0, next tick 44 cycles after resume at level 0.
- Faster and slower keys fall on the same cycle -> no level change, no counter clear. Assert reset_n low for 1 cycle mid-count -> all outputs 0 on the next edge.
- With LED_RATE_WRAP_EN defined: at level 3, faster press -> rate_level=0. Slower press -> rate_level=3. Without the macro, the same presses leave rate_level at 3 (after the first press).

Source files
------------

// File: rtl/led_rate_generator_if.sv
// Pushbutton inputs and rate/status outputs of led_rate_generator.
// master: the driving side (board pins / testbench).
// slave:  led_rate_generator itself.
interface led_rate_generator_if #(
  parameter int LEVELS = 8
);
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  logic          key_faster_n;
  logic          key_slower_n;
  logic          key_pause_n;
  logic          tick;
  logic          slow_clk;
  logic [LW-1:0] rate_level;
  logic          paused;

  modport master (
    output key_faster_n,
    output key_slower_n,
    output key_pause_n,
    input  tick,
    input  slow_clk,
    input  rate_level,
    input  paused
  );

  modport slave (
    input  key_faster_n,
    input  key_slower_n,
    input  key_pause_n,
    output tick,
    output slow_clk,
    output rate_level,
    output paused
  );
endinterface

// File: rtl/led_rate_generator.sv
// led_rate_generator: divides clk into a one-cycle tick strobe and a 50%
// duty slow_clk for led_controller. Three raw active-low pushbuttons are
// synchronised and debounced; they step the rate up/down and pause/resume.
// Optional macro LED_RATE_WRAP_EN: level stepping wraps around at both
// ends instead of saturating.
module led_rate_generator #(
  parameter int BASE_DIV        = 25_000_000,
  parameter int LEVELS          = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                 clk,
  input logic                 reset_n,
  led_rate_generator_if.slave bus
);

  localparam int LW    = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  // Counter holds 0..BASE_DIV-1; divisor values need one extra bit so a
  // power-of-two BASE_DIV is representable.
  localparam int CW    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int DBW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int NKEYS = 3;

  localparam int KEY_FASTER = 0;
  localparam int KEY_SLOWER = 1;
  localparam int KEY_PAUSE  = 2;

  localparam logic [CW:0]     BASE_W    = (CW + 1)'(BASE_DIV);
  localparam logic [LW-1:0]   TOP_LEVEL = LW'(LEVELS - 1);
  localparam logic [DBW-1:0]  DEB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Key path: synchroniser, debouncer and press detector per key
  // ---------------------------------------------------------------------
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_press;

  assign key_raw[KEY_FASTER] = bus.key_faster_n;
  assign key_raw[KEY_SLOWER] = bus.key_slower_n;
  assign key_raw[KEY_PAUSE]  = bus.key_pause_n;

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      logic           sync1_reg;
      logic           sync2_reg;
      logic           deb_reg;
      logic           press_reg;
      logic [DBW-1:0] cnt_reg;
      logic           differ;
      logic           accept;

      assign differ = (sync2_reg != deb_reg);
      // The synchronised level has disagreed long enough to be believed.
      assign accept = differ && (cnt_reg == DEB_LAST);

      // Synchronise the raw key, debounce it, and pulse once on a debounced press
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          deb_reg   <= 1'b1;
          cnt_reg   <= '0;
          press_reg <= 1'b0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          // Registered together with the debounced update so the action
          // lands on the very next edge; only 1->0 counts as a press.
          press_reg <= accept && deb_reg;
          if (!differ) begin
            cnt_reg <= '0;
          end else if (accept) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign key_press[gi] = press_reg;
    end
  endgenerate

  logic ev_faster;
  logic ev_slower;
  logic ev_pause;

  assign ev_faster = key_press[KEY_FASTER];
  assign ev_slower = key_press[KEY_SLOWER];
  assign ev_pause  = key_press[KEY_PAUSE];

  // ---------------------------------------------------------------------
  // Rate level stepping
  // ---------------------------------------------------------------------
  state_t        state_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          level_change;
  logic [CW-1:0] count_reg;
  logic          tick_reg;
  logic          slow_clk_reg;
  logic          paused_reg;

  // Next rate level from the press events; simultaneous up/down cancel out
  always_comb begin
    level_next = level_reg;
    if (ev_faster && !ev_slower) begin
      if (level_reg == TOP_LEVEL) begin
`ifdef LED_RATE_WRAP_EN
        level_next = '0;
`else
        level_next = level_reg;
`endif
      end else begin
        level_next = level_reg + 1'b1;
      end
    end else if (ev_slower && !ev_faster) begin
      if (level_reg == '0) begin
`ifdef LED_RATE_WRAP_EN
        level_next = TOP_LEVEL;
`else
        level_next = level_reg;
`endif
      end else begin
        level_next = level_reg - 1'b1;
      end
    end
  end

  // A saturated press leaves the level untouched and must not restart
  // the period, so the clear is keyed on an actual change.
  assign level_change = (level_next != level_reg);

  // ---------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------
  logic [CW:0] divisor;
  logic [CW:0] last_count;
  logic        terminal;

  assign divisor    = BASE_W >> level_reg;
  assign last_count = divisor - 1'b1;
  assign terminal   = ({1'b0, count_reg} == last_count);

  // RUN/PAUSED state machine with divide counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= RUN;
      level_reg    <= '0;
      count_reg    <= '0;
      tick_reg     <= 1'b0;
      slow_clk_reg <= 1'b0;
      paused_reg   <= 1'b0;
    end else begin
      level_reg <= level_next;
      tick_reg  <= 1'b0;
      case (state_reg)
        RUN: begin
          if (level_change) begin
            count_reg <= '0;
          end else if (terminal) begin
            // A pause arriving on terminal count still gets this tick.
            count_reg    <= '0;
            tick_reg     <= 1'b1;
            slow_clk_reg <= ~slow_clk_reg;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
          if (ev_pause) begin
            state_reg  <= PAUSED;
            paused_reg <= 1'b1;
          end
        end
        PAUSED: begin
          // Count is frozen; only a rate change may reset it.
          if (level_change) begin
            count_reg <= '0;
          end
          if (ev_pause) begin
            state_reg  <= RUN;
            paused_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= RUN;
          paused_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick       = tick_reg;
  assign bus.slow_clk   = slow_clk_reg;
  assign bus.rate_level = level_reg;
  assign bus.paused     = paused_reg;

endmodule

// File: tb/tb_led_rate_generator.sv
// Bench for led_rate_generator: randomized key stimulus, tick scoreboard
// fed by a period-arithmetic reference model, decoupled tick monitor.
module tb_led_rate_generator;

  localparam int BASE_DIV        = 64;
  localparam int LEVELS          = 4;
  localparam int DEBOUNCE_CYCLES = 4;
  // Edges from raw key fall to the edge where the action takes effect.
  localparam int LAT             = 2 + DEBOUNCE_CYCLES + 1;
`ifdef LED_RATE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  bit   mon_en  = 1'b0;

  led_rate_generator_if #(.LEVELS(LEVELS)) bus();

  led_rate_generator #(
    .BASE_DIV       (BASE_DIV),
    .LEVELS         (LEVELS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  typedef struct {
    int edge_n;
    bit slow;
    int level;
    bit paused_v;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int m_T;       // last edge the model has accounted for
  int m_c;       // count held after edge m_T
  int m_level;
  bit m_paused;
  bit m_slow;

  function automatic int lvl_after(int l, bit f, bit s);
    if (f && !s) begin
      if (l == LEVELS - 1) return WRAP ? 0 : l;
      return l + 1;
    end
    if (s && !f) begin
      if (l == 0) return WRAP ? LEVELS - 1 : l;
      return l - 1;
    end
    return l;
  endfunction

  task automatic push_tick(int e, bit s, int l, bit p);
    exp_t x;
    x.edge_n   = e;
    x.slow     = s;
    x.level    = l;
    x.paused_v = p;
    q.push_back(x);
  endtask

  // Advance through edges with no key action: ticks fall where the running
  // count wraps modulo the divisor.
  task automatic model_run_to(int e);
    int n;
    int d;
    if (e <= m_T) return;
    n = e - m_T;
    if (!m_paused) begin
      d = BASE_DIV >> m_level;
      for (int j = d - m_c; j <= n; j += d) begin
        m_slow = ~m_slow;
        push_tick(m_T + j, m_slow, m_level, 1'b0);
      end
      m_c = (m_c + n) % d;
    end
    m_T = e;
  endtask

  // Edge e carries key actions (faster f, slower s, pause p).
  task automatic model_event(int e, bit f, bit s, bit p);
    int  nl;
    int  d;
    bit  t;
    model_run_to(e - 1);
    nl = lvl_after(m_level, f, s);
    t  = 1'b0;
    if (nl != m_level) begin
      m_c = 0;
    end else if (!m_paused) begin
      d = BASE_DIV >> m_level;
      if (m_c == d - 1) begin
        m_c    = 0;
        m_slow = ~m_slow;
        t      = 1'b1;
      end else begin
        m_c++;
      end
    end
    m_level = nl;
    if (p) m_paused = ~m_paused;
    if (t) push_tick(e, m_slow, m_level, m_paused);
    m_T = e;
  endtask

  task automatic model_reset(int e);
    model_run_to(e - 1);
    m_c      = 0;
    m_level  = 0;
    m_paused = 1'b0;
    m_slow   = 1'b0;
    m_T      = e;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].edge_n < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL tick_missing: got no tick at edge %0d, required a tick", q[0].edge_n);
        void'(q.pop_front());
      end
      if (bus.tick === 1'b1) begin
        n_cmp++;
        if (q.size() == 0 || q[0].edge_n != cyc) begin
          n_err++;
          $display("FAIL tick_unexpected: got tick at edge %0d, required next tick at edge %0d",
                   cyc, (q.size() > 0) ? q[0].edge_n : -1);
        end else begin
          mon_e = q.pop_front();
          if (bus.slow_clk !== mon_e.slow || int'(bus.rate_level) != mon_e.level ||
              bus.paused !== mon_e.paused_v) begin
            n_err++;
            $display("FAIL tick_state @%0d: got slow=%0d level=%0d paused=%0d, required slow=%0d level=%0d paused=%0d",
                     cyc, bus.slow_clk, bus.rate_level, bus.paused,
                     mon_e.slow, mon_e.level, mon_e.paused_v);
          end else begin
            $display("tick @%0d slow=%0d level=%0d ok", cyc, mon_e.slow, mon_e.level);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_cycles(int n);
    model_run_to(cyc + n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(int k, logic v);
    case (k)
      0:       bus.key_faster_n = v;
      1:       bus.key_slower_n = v;
      default: bus.key_pause_n  = v;
    endcase
  endtask

  task automatic check_state(string name);
    model_run_to(cyc);
    n_cmp += 2;
    if (int'(bus.rate_level) != m_level) begin
      n_err++;
      $display("FAIL %s_level @%0d: got %0d, required %0d", name, cyc, bus.rate_level, m_level);
    end
    if (bus.paused !== m_paused) begin
      n_err++;
      $display("FAIL %s_paused @%0d: got %0d, required %0d", name, cyc, bus.paused, m_paused);
    end
    $display("state %s @%0d level=%0d paused=%0d", name, cyc, bus.rate_level, bus.paused);
  endtask

  task automatic check_zero(string name);
    n_cmp++;
    if (bus.tick !== 1'b0 || bus.slow_clk !== 1'b0 || bus.rate_level !== '0 || bus.paused !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got tick=%0d slow=%0d level=%0d paused=%0d, required all 0",
               name, bus.tick, bus.slow_clk, bus.rate_level, bus.paused);
    end
  endtask

  // One clean press of key k: low for hold cycles, then high for gap cycles.
  task automatic press(int k, int hold, int gap);
    set_key(k, 1'b0);
    model_event(cyc + LAT, k == 0, k == 1, k == 2);
    wait_cycles(hold);
    set_key(k, 1'b1);
    wait_cycles(gap);
    check_state("press");
  endtask

  task automatic press_both(int hold, int gap);
    bus.key_faster_n = 1'b0;
    bus.key_slower_n = 1'b0;
    model_event(cyc + LAT, 1'b1, 1'b1, 1'b0);
    wait_cycles(hold);
    bus.key_faster_n = 1'b1;
    bus.key_slower_n = 1'b1;
    wait_cycles(gap);
    check_state("both");
  endtask

  // Bounces shorter than the debounce window must produce nothing.
  task automatic glitch_train(int k, int reps, bit rnd);
    for (int i = 0; i < reps; i++) begin
      set_key(k, 1'b0);
      wait_cycles(rnd ? int'($urandom_range(1, DEBOUNCE_CYCLES - 1)) : DEBOUNCE_CYCLES - 1);
      set_key(k, 1'b1);
      wait_cycles(rnd ? int'($urandom_range(1, 3)) : 1);
    end
    wait_cycles(DEBOUNCE_CYCLES + 2);
    check_state("glitch");
  endtask

  task automatic pulse_reset();
    model_run_to(cyc);
    reset_n = 1'b0;
    model_reset(cyc + 1);
    @(posedge clk);
    #1;
    check_zero("reset_mid");
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    bus.key_faster_n = 1'b1;
    bus.key_slower_n = 1'b1;
    bus.key_pause_n  = 1'b1;
    reset_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_T = 0;
    model_reset(cyc);
    check_zero("reset_init");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Free running at level 0, then step up with a long press
    wait_cycles(200);
    check_state("idle");
    press(0, 20, 10);
    wait_cycles(100);

    // Bounce on faster is ignored; then clean presses saturate
    glitch_train(0, 10, 1'b0);
    for (int i = 0; i < 5; i++) press(0, 5, 8);
    wait_cycles(40);

    // Simultaneous up/down at top level
    press_both(6, 8);
    wait_cycles(30);

    // Step past the top, then below the bottom
    press(0, 5, 8);
    press(1, 5, 8);
    for (int i = 0; i < 4; i++) press(1, 5, 8);
    press(1, 5, 8);
    wait_cycles(70);

    // Reset mid-count, then pause so the count is held at 20
    wait_cycles(17);
    pulse_reset();
    wait_cycles(LAT + 6);
    press(2, 5, 10);
    wait_cycles(285);
    press(2, 5, 10);
    wait_cycles(150);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 10));
      case (op)
        0, 1:    press(0, int'($urandom_range(4, 12)), int'($urandom_range(6, 14)));
        2, 3:    press(1, int'($urandom_range(4, 12)), int'($urandom_range(6, 14)));
        4:       press(2, int'($urandom_range(4, 12)), int'($urandom_range(6, 14)));
        5:       press_both(int'($urandom_range(4, 12)), int'($urandom_range(6, 14)));
        6:       glitch_train(int'($urandom_range(0, 2)), int'($urandom_range(1, 5)), 1'b1);
        7:       pulse_reset();
        default: wait_cycles(int'($urandom_range(1, 150)));
      endcase
    end

    wait_cycles(200);
    check_state("final");
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL tick_leftover: got %0d unconsumed expected ticks, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, so this only fires on a hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of stimulus by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
